// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - score-to-BCD sequencer and digit source mux for the seven-segment scanner
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   score        14-bit binary score (saturated to 9999)
//   score_valid  one-cycle conversion request
//   level        current level 0..15
//   level_up     one-cycle pulse, starts/restarts the level overlay
//   game_over    level signal, forces "EEEE" on the display
//   busy         conversion in progress
//   s4..s1       digit codes to the scanner, s4 leftmost

module score_display_ctrl #(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] score,
    input  logic        score_valid,
    input  logic [3:0]  level,
    input  logic        level_up,
    input  logic        game_over,
    output logic        busy,
    output logic [3:0]  s4,
    output logic [3:0]  s3,
    output logic [3:0]  s2,
    output logic [3:0]  s1
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [13:0]        bin;
    logic [15:0]        bcd;
    logic [3:0]         iter;
    logic [13:0]        pend_val;
    logic               pending;
    logic [15:0]        digits;

    logic [13:0]        score_sat;
    logic [15:0]        bcd_adj;
    logic [15:0]        bcd_shift;
    logic [13:0]        bin_shift;
    logic               commit;
    logic               restart;

    logic [HOLD_W-1:0]  hold_cnt;
    logic [3:0]         lvl;
    logic               overlay;
    logic [3:0]         lvl_tens;
    logic [3:0]         lvl_ones;

    // ---------------------------------------------------------------
    // Shift-add-3 datapath
    // ---------------------------------------------------------------
    always_comb begin
        score_sat = (score > 14'd9999) ? 14'd9999 : score;
        bcd_adj   = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[14:0], bin[13]};
        bin_shift = {bin[12:0], 1'b0};
        commit    = (state == CONV) && (iter == 4'd13);
        // A request arriving on the commit cycle counts as pending too, so
        // exactly one restart follows and the newest value is used.
        restart   = commit && (pending || score_valid);
    end

    // ---------------------------------------------------------------
    // Conversion FSM: state register / next state / outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (score_valid) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (commit && !restart) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin      <= '0;
            bcd      <= '0;
            iter     <= '0;
            pend_val <= '0;
            pending  <= 1'b0;
            digits   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        bin  <= score_sat;
                        bcd  <= '0;
                        iter <= '0;
                    end
                end
                CONV: begin
                    if (commit) begin
                        digits <= bcd_shift;
                        if (restart) begin
                            bin     <= score_valid ? score_sat : pend_val;
                            bcd     <= '0;
                            iter    <= '0;
                            pending <= 1'b0;
                        end
                    end else begin
                        bin  <= bin_shift;
                        bcd  <= bcd_shift;
                        iter <= iter + 4'd1;
                        if (score_valid) begin
                            pend_val <= score_sat;
                            pending  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Level overlay timer; a reload beats the final decrement
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            lvl      <= '0;
        end else if (level_up) begin
            hold_cnt <= HOLD_LOAD;
            lvl      <= level;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    always_comb begin
        overlay  = (hold_cnt != '0);
        lvl_tens = (lvl >= 4'd10) ? 4'd1 : 4'd0;
        lvl_ones = (lvl >= 4'd10) ? lvl - 4'd10 : lvl;
    end

    // ---------------------------------------------------------------
    // Registered display source mux
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            {s4, s3, s2, s1} <= '0;
        end else if (game_over) begin
            {s4, s3, s2, s1} <= 16'hFFFF;
        end else if (overlay) begin
            {s4, s3, s2, s1} <= {4'd0, 4'd0, lvl_tens, lvl_ones};
        end else begin
            {s4, s3, s2, s1} <= digits;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - directed bench for score_display_ctrl

module tb_score_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] score;
    logic        score_valid;
    logic [3:0]  level;
    logic        level_up;
    logic        game_over;
    logic        busy;
    logic [3:0]  s4, s3, s2, s1;

    int total = 0;
    int bad   = 0;

    score_display_ctrl #(.HOLD_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .score_valid (score_valid),
        .level       (level),
        .level_up    (level_up),
        .game_over   (game_over),
        .busy        (busy),
        .s4          (s4),
        .s3          (s3),
        .s2          (s2),
        .s1          (s1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] disp();
        return {s4, s3, s2, s1};
    endfunction

    // one rising edge, then settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // request a conversion and run through the output register stage (E15)
    task automatic convert(input logic [13:0] v);
        score       = v;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
        ticks(15);
    endtask

    task automatic test_reset();
        rst = 1'b1; score = '0; score_valid = 0; level = '0; level_up = 0; game_over = 0;
        ticks(2);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++;
        if (disp() !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h exp=0000", disp()); end
    endtask

    task automatic test_basic();
        int busy_cycles = 0;
        score = 14'd1234; score_valid = 1'b1;
        tick();                         // E0
        score_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (busy === 1'b1) busy_cycles++;
            tick();                     // E1..E14
        end
        total++;
        if (busy_cycles != 14) begin bad++; $display("FAIL basic_busy_len got=%0d exp=14", busy_cycles); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after_e14 got=%b exp=0", busy); end
        total++;
        if (disp() !== 16'h0000) begin bad++; $display("FAIL basic_e14_old got=%h exp=0000", disp()); end
        tick();                         // E15
        total++;
        if (disp() !== 16'h1234) begin bad++; $display("FAIL basic_1234 got=%h exp=1234", disp()); end
    endtask

    task automatic test_saturate();
        convert(14'd16383);
        total++;
        if (disp() !== 16'h9999) begin bad++; $display("FAIL sat_16383 got=%h exp=9999", disp()); end
        convert(14'd0);
        total++;
        if (disp() !== 16'h0000) begin bad++; $display("FAIL zero got=%h exp=0000", disp()); end
        convert(14'd9999);
        total++;
        if (disp() !== 16'h9999) begin bad++; $display("FAIL exact_9999 got=%h exp=9999", disp()); end
        convert(14'd10000);
        total++;
        if (disp() !== 16'h9999) begin bad++; $display("FAIL sat_10000 got=%h exp=9999", disp()); end
        convert(14'd5090);
        total++;
        if (disp() !== 16'h5090) begin bad++; $display("FAIL conv_5090 got=%h exp=5090", disp()); end
    endtask

    task automatic test_back_to_back();
        int seen_250 = 0;
        score = 14'd100; score_valid = 1'b1;
        tick();                         // E0
        score_valid = 1'b0;
        ticks(2);                       // E1, E2
        score = 14'd250; score_valid = 1'b1;
        tick();                         // E3
        score_valid = 1'b0;
        tick();                         // E4
        score = 14'd777; score_valid = 1'b1;
        tick();                         // E5
        score_valid = 1'b0;
        ticks(9);                       // E6..E14
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap got=%b exp=1", busy); end
        tick();                         // E15
        total++;
        if (disp() !== 16'h0100) begin bad++; $display("FAIL b2b_first got=%h exp=0100", disp()); end
        for (int i = 0; i < 13; i++) begin
            tick();                     // E16..E28
            if (disp() === 16'h0250) seen_250++;
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b exp=0", busy); end
        tick();                         // E29
        total++;
        if (disp() !== 16'h0777) begin bad++; $display("FAIL b2b_final got=%h exp=0777", disp()); end
        total++;
        if (seen_250 != 0) begin bad++; $display("FAIL b2b_250_shown got=%0d exp=0", seen_250); end
    endtask

    task automatic test_pending_at_commit();
        score = 14'd1000; score_valid = 1'b1;
        tick();                         // E0
        score_valid = 1'b0;
        ticks(4);                       // E1..E4
        score = 14'd2000; score_valid = 1'b1;
        tick();                         // E5: pending = 2000
        score_valid = 1'b0;
        ticks(8);                       // E6..E13
        score = 14'd3000; score_valid = 1'b1;
        tick();                         // E14: commit, 3000 replaces 2000
        score_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL pc_restart got=%b exp=1", busy); end
        tick();                         // E15
        total++;
        if (disp() !== 16'h1000) begin bad++; $display("FAIL pc_first got=%h exp=1000", disp()); end
        ticks(13);                      // E28
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL pc_single_restart got=%b exp=0", busy); end
        tick();                         // E29
        total++;
        if (disp() !== 16'h3000) begin bad++; $display("FAIL pc_final got=%h exp=3000", disp()); end
        ticks(16);
        total++;
        if (disp() !== 16'h3000 || busy !== 1'b0) begin
            bad++; $display("FAIL pc_no_extra got=%h/%b exp=3000/0", disp(), busy);
        end
    endtask

    task automatic test_overlay();
        int ok;
        convert(14'd777);
        level = 4'd12; level_up = 1'b1;
        tick();                         // L0
        level_up = 1'b0;
        ok = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (disp() !== 16'h0012) ok = 0;
        end
        total++;
        if (ok == 0) begin bad++; $display("FAIL ovl_12_window got=%h exp=0012", disp()); end
        tick();                         // L0+9
        total++;
        if (disp() !== 16'h0777) begin bad++; $display("FAIL ovl_12_end got=%h exp=0777", disp()); end

        // retrigger on the 5th cycle
        level = 4'd12; level_up = 1'b1;
        tick();                         // L0
        level_up = 1'b0;
        ticks(4);                       // L0+1..L0+4
        level = 4'd3; level_up = 1'b1;
        tick();                         // L1 = L0+5
        level_up = 1'b0;
        total++;
        if (disp() !== 16'h0012) begin bad++; $display("FAIL ovl_retrig_old got=%h exp=0012", disp()); end
        ok = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (disp() !== 16'h0003) ok = 0;
        end
        total++;
        if (ok == 0) begin bad++; $display("FAIL ovl_3_window got=%h exp=0003", disp()); end
        tick();
        total++;
        if (disp() !== 16'h0777) begin bad++; $display("FAIL ovl_3_end got=%h exp=0777", disp()); end

        // reload collides with the final decrement
        level = 4'd9; level_up = 1'b1;
        tick();                         // L0
        level_up = 1'b0;
        ticks(7);                       // counter now 1
        level = 4'd7; level_up = 1'b1;
        tick();                         // L0+8
        level_up = 1'b0;
        total++;
        if (disp() !== 16'h0009) begin bad++; $display("FAIL ovl_last_old got=%h exp=0009", disp()); end
        ok = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (disp() !== 16'h0007) ok = 0;
        end
        total++;
        if (ok == 0) begin bad++; $display("FAIL ovl_reload_wins got=%h exp=0007", disp()); end
        tick();
        total++;
        if (disp() !== 16'h0777) begin bad++; $display("FAIL ovl_reload_end got=%h exp=0777", disp()); end
    endtask

    task automatic test_game_over();
        level = 4'd4; level_up = 1'b1;
        tick();                         // L0
        level_up = 1'b0;
        tick();
        total++;
        if (disp() !== 16'h0004) begin bad++; $display("FAIL go_pre_overlay got=%h exp=0004", disp()); end
        game_over = 1'b1; score = 14'd4321; score_valid = 1'b1;
        tick();                         // E0
        score_valid = 1'b0;
        total++;
        if (disp() !== 16'hFFFF) begin bad++; $display("FAIL go_over_overlay got=%h exp=FFFF", disp()); end
        ticks(14);                      // E14 commit, overlay long expired
        total++;
        if (disp() !== 16'hFFFF || busy !== 1'b0) begin
            bad++; $display("FAIL go_hold got=%h/%b exp=FFFF/0", disp(), busy);
        end
        game_over = 1'b0;
        total++;
        if (disp() !== 16'hFFFF) begin bad++; $display("FAIL go_release_lag got=%h exp=FFFF", disp()); end
        tick();
        total++;
        if (disp() !== 16'h4321) begin bad++; $display("FAIL go_release got=%h exp=4321", disp()); end
    endtask

    task automatic test_reset_mid_conv();
        score = 14'd1111; score_valid = 1'b1;
        tick();                         // E0
        score_valid = 1'b0;
        ticks(7);                       // E1..E7
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (disp() !== 16'h0000 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid got=%h/%b exp=0000/0", disp(), busy);
        end
        ticks(20);
        total++;
        if (disp() !== 16'h0000 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_no_stale got=%h/%b exp=0000/0", disp(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_back_to_back();
        test_pending_at_commit();
        test_overlay();
        test_game_over();
        test_reset_mid_conv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Sequencing controller for the 4-digit seven-segment scanner in the Tetris top level. It converts the binary game score to four BCD digits with a sequential shift-add-3 engine and feeds the scanner's four digit inputs (s4..s1). It also shares those digit inputs between three sources in fixed priority: game-over pattern, a timed level-up overlay, and the score.

## Interface
- HOLD_CYCLES, 50000000, length of the level overlay in clk cycles (1 s at 50 MHz); must be ≥ 1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- score  in  14  binary score; values > 9999 saturate to 9999
- score_valid  in  1  single-cycle pulse: request conversion of `score`
- level  in  4  current level, 0..15
- level_up  in  1  single-cycle pulse: start or restart the level overlay
- game_over  in  1  level signal; when high, overrides all display sources
- busy  out  1  high while a conversion is in progress
- s4  out  4  thousands digit to the scanner (leftmost)
- s3  out  4  hundreds digit to the scanner
- s2  out  4  tens digit to the scanner
- s1  out  4  ones digit to the scanner (rightmost)

## Operation
- Conversion FSM states:
  - IDLE
    - On score_valid, capture min(score, 9999) into a 14-bit shift register.
    - Clear the 16-bit BCD accumulator and iteration counter, then go to CONV.
  - CONV
    - Each cycle: add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
    - On the 14th iteration (counter == 13), commit the accumulator to the score digit registers.
    - After the commit, go to IDLE, or restart if a request is pending.
- Pending request:
  - score_valid while busy latches the current score (saturated) into a pending register and sets pending.
  - A later pulse while busy overwrites the pending value (last value wins).
  - At commit with pending set, the FSM loads the pending value, clears pending and stays in CONV with counter 0. There is no IDLE gap.
- Level overlay:
  - level_up captures `level` and loads the hold counter to HOLD_CYCLES.
  - The overlay is active while the counter is nonzero; the counter decrements each cycle.
  - level_up while active recaptures level and reloads the counter.
  - level_up and the counter's final decrement in the same cycle: the reload wins.
- Output mux, registered, priority high to low:
  - game_over = 1 → s4..s1 = 4'hF each. The scanner shows "EEEE".
  - overlay active → s4 = 0, s3 = 0, s2 = level/10, s1 = level%10. Example: level 12 → 0,0,1,2.
  - otherwise → the committed score digits.
- Score conversion continues regardless of which source is displayed. Committed digits appear once the overlay or game_over ends.

## Timing
- Reset values:
  - busy = 0.
  - s4..s1 = 0.
  - Score digit registers = 0.
  - Pending cleared, overlay counter = 0, FSM = IDLE.
- Reset mid-conversion aborts with no commit. Previously displayed digits are lost and return to 0.
- Capture on edge E0 (score_valid high in the preceding cycle).
  - busy = 1 from E0 until the commit edge E14.
  - Digit registers update at E14.
  - s4..s1 show the new score after edge E15, since the output mux adds one register stage.
  - busy = 0 after E14 unless a pending restart keeps it high.
  - Back-to-back conversions take 14 cycles each.
- score_valid in the same cycle as a commit with pending already set: the new value replaces the pending value. Exactly one restart follows.
- Overlay: level_up sampled at edge L0. The overlay is visible on s outputs from L0+1 for exactly HOLD_CYCLES cycles.
- game_over takes effect on the outputs one cycle after it changes.

## Test plan
- Reset, then score = 1234 with score_valid at E0 → busy high for 14 cycles; s4..s1 = 1,2,3,4 after E15; busy = 0 after E14.
- score = 16383 → saturates; s4..s1 = 9,9,9,9. score = 0 → 0,0,0,0.
- score = 100 at E0, then score = 250 and 777 pulsed at E3 and E5 → first commit shows 0,1,0,0. Immediate restart with no gap; final display 0,7,7,7; 250 is never displayed.
- HOLD_CYCLES = 8, level = 12, level_up → s4..s1 = 0,0,1,2 for exactly 8 cycles, then the score digits return. A retrigger at cycle 5 with level = 3 → 0,0,0,3 for 8 more cycles.
- game_over high during the overlay and during a conversion → 4'hF on all digits next cycle. Conversion still commits; the correct score is shown after game_over drops (overlay expired).
- rst asserted at iteration 7 of a conversion → all outputs 0 next cycle, busy = 0. No stale commit appears afterwards.
